store_merge_unit: RTL and testbench

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

---
 rtl/store_merge_unit.sv | 138 +++++++++++++
 tb/tb_store_merge_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// Store merge unit: word stores write straight through, half/byte stores read-modify-write the aligned word.
// Define STORE_MISALIGN_CHK_EN to reject misaligned half/word stores with a one-cycle err pulse.
module store_merge_unit #(
  parameter int unsigned CPU_WORD = 32,
  parameter int unsigned HALF_LEN = 16,
  parameter int unsigned BYTE_LEN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic                sw,
  input  logic                sh,
  input  logic                sb,
  input  logic [CPU_WORD-1:0] addr,
  input  logic [CPU_WORD-1:0] wdata,
  output logic                ready,
  output logic                done,
  output logic                err,
  output logic [CPU_WORD-1:0] mem_addr,
  output logic                mem_re,
  input  logic [CPU_WORD-1:0] mem_rdata,
  output logic                mem_we,
  output logic [CPU_WORD-1:0] mem_wdata
);

  typedef enum logic [1:0] {IDLE, READ, MERGE, WRITE} state_t;
  typedef enum logic [1:0] {OP_W, OP_H, OP_B} op_t;

  state_t              state;
  op_t                 op_reg;
  op_t                 op_dec_c;
  logic [CPU_WORD-1:0] addr_reg;
  logic [CPU_WORD-1:0] wdata_reg;
  logic                accept_c;
  logic                misalign_c;

  // Replace one little-endian lane of the read word with the store data LSBs.
  function automatic logic [CPU_WORD-1:0] merge_lane(
    input logic [CPU_WORD-1:0] rd,
    input logic [CPU_WORD-1:0] wd,
    input op_t                 op,
    input logic [1:0]          lane
  );
    logic [CPU_WORD-1:0] m;
    m = rd;
    if (op == OP_B)
      m[BYTE_LEN*32'(lane) +: BYTE_LEN] = wd[BYTE_LEN-1:0];
    else if (op == OP_H)
      m[HALF_LEN*32'(lane[1]) +: HALF_LEN] = wd[HALF_LEN-1:0];
    else
      m = wd;
    return m;
  endfunction

  // Strobe decode with sh > sb > sw priority.
  always_comb begin
    op_dec_c = OP_W;
    if (sh)
      op_dec_c = OP_H;
    else if (sb)
      op_dec_c = OP_B;
    accept_c = ready && req_valid && (sw || sh || sb);
`ifdef STORE_MISALIGN_CHK_EN
    misalign_c = ((op_dec_c == OP_H) && addr[0]) ||
                 ((op_dec_c == OP_W) && (addr[1:0] != 2'b00));
`else
    misalign_c = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_reg    <= OP_W;
      addr_reg  <= '0;
      wdata_reg <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            if (misalign_c) begin
              // Rejected store: no memory traffic, unit stays idle.
              err <= 1'b1;
            end else begin
              addr_reg  <= addr;
              wdata_reg <= wdata;
              op_reg    <= op_dec_c;
              ready     <= 1'b0;
              mem_addr  <= {addr[CPU_WORD-1:2], 2'b00};
              if (op_dec_c == OP_W) begin
                state     <= WRITE;
                mem_we    <= 1'b1;
                done      <= 1'b1;
                mem_wdata <= wdata;
              end else begin
                state  <= READ;
                mem_re <= 1'b1;
              end
            end
          end
        end
        READ: begin
          state    <= MERGE;
          mem_addr <= {addr_reg[CPU_WORD-1:2], 2'b00};
        end
        MERGE: begin
          // mem_rdata is valid here, one cycle after mem_re.
          state     <= WRITE;
          mem_we    <= 1'b1;
          done      <= 1'b1;
          mem_wdata <= merge_lane(mem_rdata, wdata_reg, op_reg, addr_reg[1:0]);
        end
        WRITE: begin
          state     <= IDLE;
          ready     <= 1'b1;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: latency-table reference model with shadow memory, directed and random stores.
module tb_store_merge_unit;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n, req_valid, sw, sh, sb;
  logic [W-1:0] addr, wdata, mem_rdata;
  logic         ready, done, err, mem_re, mem_we;
  logic [W-1:0] mem_addr, mem_wdata;

  always #5 clk = ~clk;

  store_merge_unit #(.CPU_WORD(32), .HALF_LEN(16), .BYTE_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .sw(sw), .sh(sh), .sb(sb),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int done_count = 0;

  logic [W-1:0] dut_mem [logic [W-1:0]];
  logic [W-1:0] ref_mem [logic [W-1:0]];

  function automatic logic [W-1:0] init_val(input logic [W-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [W-1:0] dut_get(input logic [W-1:0] a);
    return dut_mem.exists(a) ? dut_mem[a] : init_val(a);
  endfunction

  function automatic logic [W-1:0] ref_get(input logic [W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Memory environment: writes land on the edge, reads return one cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) begin
      dut_mem[mem_addr] = mem_wdata;
      we_count++;
    end
    if (done) done_count++;
    if (mem_re) mem_rdata <= dut_get(mem_addr);
    else        mem_rdata <= $urandom;
  end

  // Reference model: a transaction is a cycle count since accept plus its final write word.
  logic         m_busy = 1'b0;
  int           m_cnt = 0;
  int           m_last = 0;
  logic [W-1:0] m_addr = '0;
  logic [W-1:0] m_data = '0;
  logic         exp_ready, exp_done, exp_err, exp_re, exp_we, exp_rstw;
  logic [W-1:0] exp_addr, exp_wdata;

  task automatic model_step(input logic r, v, w, h, b, input logic [W-1:0] a, d);
    logic is_h, is_b, mis;
    logic [W-1:0] old, mask;
    int sh_amt;
    exp_err  = 1'b0;
    exp_rstw = 1'b0;
    if (!r) begin
      m_busy   = 1'b0;
      exp_rstw = 1'b1;
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt > m_last) m_busy = 1'b0;
    end else if (v && (w || h || b)) begin
      is_h = h;
      is_b = !h && b;
`ifdef STORE_MISALIGN_CHK_EN
      mis = (is_h && a[0]) || (!is_h && !is_b && (a % 4 != 0));
`else
      mis = 1'b0;
`endif
      if (mis) begin
        exp_err = 1'b1;
      end else begin
        m_busy = 1'b1;
        m_cnt  = 1;
        m_addr = a & ~32'd3;
        if (is_h) begin
          m_last = 3;
          sh_amt = ((a / 2) % 2) * 16;
          mask   = 32'hFFFF << sh_amt;
          old    = ref_get(m_addr);
          m_data = (old & ~mask) | ((d & 32'hFFFF) << sh_amt);
        end else if (is_b) begin
          m_last = 3;
          sh_amt = (a % 4) * 8;
          mask   = 32'hFF << sh_amt;
          old    = ref_get(m_addr);
          m_data = (old & ~mask) | ((d & 32'hFF) << sh_amt);
        end else begin
          m_last = 1;
          m_data = d;
        end
      end
    end
    exp_ready = !m_busy;
    exp_re    = m_busy && (m_last == 3) && (m_cnt == 1);
    exp_we    = m_busy && (m_cnt == m_last);
    exp_done  = exp_we;
    exp_addr  = m_busy ? m_addr : '0;
    exp_wdata = exp_rstw ? '0 : m_data;
    if (exp_we) ref_mem[m_addr] = m_data;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic check_outputs();
    chk("ready", W'(ready), W'(exp_ready));
    chk("done", W'(done), W'(exp_done));
    chk("err", W'(err), W'(exp_err));
    chk("mem_re", W'(mem_re), W'(exp_re));
    chk("mem_we", W'(mem_we), W'(exp_we));
    chk("mem_addr", mem_addr, exp_addr);
    if (exp_we || exp_rstw) chk("mem_wdata", mem_wdata, exp_wdata);
  endtask

  task automatic step(input logic r, v, w, h, b, input logic [W-1:0] a, d);
    @(negedge clk);
    check_outputs();
    rst_n = r; req_valid = v; sw = w; sh = h; sb = b; addr = a; wdata = d;
    model_step(r, v, w, h, b, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
  endtask

  task automatic preload(input logic [W-1:0] a, input logic [W-1:0] v);
    dut_mem[a] = v;
    ref_mem[a] = v;
  endtask

  initial begin
    int c_we, c_done;
    rst_n = 1'b0; req_valid = 1'b0; sw = 1'b0; sh = 1'b0; sb = 1'b0;
    addr = '0; wdata = '0;
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("rst_ready", W'(ready), 32'd1);
    chk("rst_mem_addr", mem_addr, 32'd0);

    // Word store.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF);
    idle(3);
    chk("word_mem", dut_get(32'h100), 32'hDEADBEEF);
    chk("word_ref", ref_get(32'h100), 32'hDEADBEEF);

    // Byte store into lane 3.
    preload(32'h200, 32'h11223344);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h203, 32'h000000AB);
    idle(4);
    chk("byte_mem", dut_get(32'h200), 32'hAB223344);
    chk("byte_ref", ref_get(32'h200), 32'hAB223344);

    // Half store into upper lane, then same with sb also set.
    preload(32'h300, 32'h11223344);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h302, 32'h0000CAFE);
    idle(4);
    chk("half_mem", dut_get(32'h300), 32'hCAFE3344);
    chk("half_ref", ref_get(32'h300), 32'hCAFE3344);
    preload(32'h300, 32'h11223344);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h302, 32'h0000CAFE);
    idle(4);
    chk("half_prio_mem", dut_get(32'h300), 32'hCAFE3344);

    // Reset during MERGE aborts the store.
    preload(32'h500, 32'h55667788);
    c_we = we_count;
    c_done = done_count;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h501, 32'h00000099);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    chk("abort_ready", W'(ready), 32'd1);
    idle(4);
    chk("abort_we", W'(we_count - c_we), 32'd0);
    chk("abort_done", W'(done_count - c_done), 32'd0);
    chk("abort_mem", dut_get(32'h500), 32'h55667788);

    // Misaligned half store.
    preload(32'h400, 32'hAABBCCDD);
    c_we = we_count;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h401, 32'h00001234);
    idle(4);
`ifdef STORE_MISALIGN_CHK_EN
    chk("misalign_mem", dut_get(32'h400), 32'hAABBCCDD);
    chk("misalign_we", W'(we_count - c_we), 32'd0);
`else
    chk("misalign_mem", dut_get(32'h400), 32'hAABB1234);
    chk("misalign_we", W'(we_count - c_we), 32'd1);
`endif

    // Random traffic over a small address window with occasional resets.
    repeat (3000) begin
      logic [2:0] s;
      s = 3'($urandom);
      step(($urandom % 64) != 0, 1'($urandom), s[0], s[1], s[2],
           32'h1000 + ($urandom % 16), $urandom);
    end
    idle(6);
    @(negedge clk);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
